// File: rtl/mem_access_stage.sv
// MEM pipeline stage: big-endian byte-addressable data memory plus the MEM/WB register.
// Latency: loads and WB controls are registered on one edge; the branch outputs to IF are combinational.
// Backpressure: none. Every edge captures a new EX/MEM bundle, with no stall or enable.
module mem_access_stage #(
  parameter int DMEM_DEPTH = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EX_MEM_zero_in,
  input  logic        EX_MEM_branch_in,
  input  logic        EX_MEM_RegWrite_in,
  input  logic        EX_MEM_MemWrite_in,
  input  logic        EX_MEM_MemRead_in,
  input  logic        EX_MEM_MemToReg_in,
  input  logic [1:0]  EX_MEM_load_mode_in,
  input  logic [4:0]  EX_MEM_dest_in,
  input  logic [31:0] EX_MEM_aluResult_in,
  input  logic [31:0] EX_MEM_rt_in,
  input  logic [31:0] EX_MEM_pc_in,
  output logic [31:0] MEM_IF_BR_NEXT_INS_ADR,
  output logic        MEM_IF_MEM_WRITE,
  output logic        MEM_WB_RegWrite,
  output logic        MEM_WB_MemToReg,
  output logic [31:0] MEM_WB_read_data,
  output logic [31:0] MEM_WB_alu_result,
  output logic [4:0]  MEM_WB_dest
);

  localparam int AW = $clog2(DMEM_DEPTH);

  // Access-size encodings carried on EX_MEM_load_mode_in.
  localparam logic [1:0] MODE_WORD  = 2'b00;
  localparam logic [1:0] MODE_HALF  = 2'b01;
  localparam logic [1:0] MODE_BYTE  = 2'b10;
  localparam logic [1:0] MODE_UBYTE = 2'b11;

  // Data memory. It is deliberately left out of reset so its contents survive RST.
  logic [31:0] dmem [DMEM_DEPTH];

  logic [AW-1:0] word_idx;
  logic [1:0]    byte_off;
  logic [31:0]   rd_word;
  logic [31:0]   load_val;
  logic [3:0]    wr_be;
  logic [31:0]   wr_word;

  // Address bits above the memory size are dropped, so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^EX_MEM_aluResult_in[31:AW+2];

  assign word_idx = EX_MEM_aluResult_in[AW+1:2];
  assign byte_off = EX_MEM_aluResult_in[1:0];
  assign rd_word  = dmem[word_idx];

  // Branch resolution to IF. The target passes through whether or not the branch is taken.
  assign MEM_IF_MEM_WRITE       = EX_MEM_branch_in & EX_MEM_zero_in;
  assign MEM_IF_BR_NEXT_INS_ADR = EX_MEM_pc_in;

  // Load lane extraction. Big-endian: offset 0 is bits 31:24.
  // A halfword access uses only addr[1], so it can never straddle a word.
  always_comb begin
    load_val = 32'h0;
    unique case (EX_MEM_load_mode_in)
      MODE_WORD: load_val = rd_word;
      MODE_HALF: begin
        if (byte_off[1]) load_val = {{16{rd_word[15]}}, rd_word[15:0]};
        else             load_val = {{16{rd_word[31]}}, rd_word[31:16]};
      end
      MODE_BYTE: begin
        unique case (byte_off)
          2'd0: load_val = {{24{rd_word[31]}}, rd_word[31:24]};
          2'd1: load_val = {{24{rd_word[23]}}, rd_word[23:16]};
          2'd2: load_val = {{24{rd_word[15]}}, rd_word[15:8]};
          default: load_val = {{24{rd_word[7]}}, rd_word[7:0]};
        endcase
      end
      MODE_UBYTE: begin
        unique case (byte_off)
          2'd0: load_val = {24'h0, rd_word[31:24]};
          2'd1: load_val = {24'h0, rd_word[23:16]};
          2'd2: load_val = {24'h0, rd_word[15:8]};
          default: load_val = {24'h0, rd_word[7:0]};
        endcase
      end
      default: load_val = 32'h0;
    endcase
  end

  // Store lane steering: replicate the store data into every lane and select lanes with byte enables.
  always_comb begin
    wr_be   = 4'b0000;
    wr_word = 32'h0;
    unique case (EX_MEM_load_mode_in)
      MODE_WORD: begin
        wr_be   = 4'b1111;
        wr_word = EX_MEM_rt_in;
      end
      MODE_HALF: begin
        wr_word = {2{EX_MEM_rt_in[15:0]}};
        wr_be   = byte_off[1] ? 4'b0011 : 4'b1100;
      end
      default: begin
        wr_word = {4{EX_MEM_rt_in[7:0]}};
        unique case (byte_off)
          2'd0: wr_be = 4'b1000;
          2'd1: wr_be = 4'b0100;
          2'd2: wr_be = 4'b0010;
          default: wr_be = 4'b0001;
        endcase
      end
    endcase
  end

  // Byte-lane memory write. RST is sampled on the edge, so a store that coincides with reset is dropped.
  // The nonblocking update lets a same-edge load observe the old word.
  always_ff @(posedge CLK) begin
    if (!RST && EX_MEM_MemWrite_in) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) dmem[word_idx][b*8 +: 8] <= wr_word[b*8 +: 8];
      end
    end
  end

  // MEM/WB register. It is captured every edge and cleared asynchronously by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      MEM_WB_RegWrite   <= 1'b0;
      MEM_WB_MemToReg   <= 1'b0;
      MEM_WB_read_data  <= 32'h0;
      MEM_WB_alu_result <= 32'h0;
      MEM_WB_dest       <= 5'd0;
    end else begin
      MEM_WB_RegWrite   <= EX_MEM_RegWrite_in;
      MEM_WB_MemToReg   <= EX_MEM_MemToReg_in;
      MEM_WB_read_data  <= EX_MEM_MemRead_in ? load_val : 32'h0;
      MEM_WB_alu_result <= EX_MEM_aluResult_in;
      MEM_WB_dest       <= EX_MEM_dest_in;
    end
  end

endmodule
